// File: rtl/dmem_arbiter_if.sv
// Shared data-memory port bundle: two cache requesters on one side,
// the 256-bit memory on the other.
interface dmem_arbiter_if #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  logic              r0_enable_i;
  logic              r0_write_i;
  logic [ADDR_W-1:0] r0_addr_i;
  logic [DATA_W-1:0] r0_data_i;
  logic              r0_ack_o;
  logic [DATA_W-1:0] r0_data_o;
  logic [CNT_W-1:0]  r0_count_o;

  logic              r1_enable_i;
  logic              r1_write_i;
  logic [ADDR_W-1:0] r1_addr_i;
  logic [DATA_W-1:0] r1_data_i;
  logic              r1_ack_o;
  logic [DATA_W-1:0] r1_data_o;
  logic [CNT_W-1:0]  r1_count_o;

  logic              mem_enable_o;
  logic              mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_data_i;

  logic              grant_o;
  logic              timeout_o;

  modport slave (
    input  r0_enable_i, r0_write_i, r0_addr_i, r0_data_i,
    output r0_ack_o, r0_data_o, r0_count_o,
    input  r1_enable_i, r1_write_i, r1_addr_i, r1_data_i,
    output r1_ack_o, r1_data_o, r1_count_o,
    output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    input  mem_ack_i, mem_data_i,
    output grant_o, timeout_o
  );

  modport master (
    output r0_enable_i, r0_write_i, r0_addr_i, r0_data_i,
    input  r0_ack_o, r0_data_o, r0_count_o,
    output r1_enable_i, r1_write_i, r1_addr_i, r1_data_i,
    input  r1_ack_o, r1_data_o, r1_count_o,
    input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    output mem_ack_i, mem_data_i,
    input  grant_o, timeout_o
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for the shared data-memory port, with
// per-requester transaction counters and a sticky stall watchdog.
module dmem_arbiter #(
  parameter int DATA_W      = 256,
  parameter int ADDR_W      = 32,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic           clk_i,
  input logic           rst_i,
  dmem_arbiter_if.slave bus
);

  localparam int WW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RELEASE
  } state_t;

  state_t           state;
  logic             grant;
  logic             rr_ptr;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
  logic [WW-1:0]    wcnt;
  logic             timeout;
  logic             busy;
  logic             any_req;

  assign busy    = (state == BUSY);
  assign any_req = bus.r0_enable_i | bus.r1_enable_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      grant   <= 1'b0;
      rr_ptr  <= 1'b0;
      cnt0    <= '0;
      cnt1    <= '0;
      wcnt    <= '0;
      timeout <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            if (bus.r0_enable_i && bus.r1_enable_i)
              grant <= rr_ptr;
            else
              grant <= bus.r1_enable_i;
            wcnt  <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (bus.mem_ack_i) begin
            rr_ptr <= ~grant;
            if (!grant && !(&cnt0)) cnt0 <= cnt0 + 1'b1;
            if (grant && !(&cnt1))  cnt1 <= cnt1 + 1'b1;
            state  <= RELEASE;
          end else if (TIMEOUT_CYC != 0 && !timeout) begin
            // Counter freezes once the flag is set so it cannot wrap.
            wcnt <= wcnt + 1'b1;
            if (wcnt + 1'b1 == WW'(TIMEOUT_CYC))
              timeout <= 1'b1;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_enable_o = busy;
  assign bus.mem_write_o  = busy &
    (grant ? bus.r1_write_i : bus.r0_write_i);
  assign bus.mem_addr_o   = grant ? bus.r1_addr_i : bus.r0_addr_i;
  assign bus.mem_data_o   = grant ? bus.r1_data_i : bus.r0_data_i;

  assign bus.r0_ack_o   = busy & bus.mem_ack_i & ~grant;
  assign bus.r1_ack_o   = busy & bus.mem_ack_i & grant;
  assign bus.r0_data_o  = bus.mem_data_i;
  assign bus.r1_data_o  = bus.mem_data_i;
  assign bus.r0_count_o = cnt0;
  assign bus.r1_count_o = cnt1;
  assign bus.grant_o    = grant;
  assign bus.timeout_o  = timeout;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: arbitration order, latency,
// stray acks and the watchdog on a short-timeout instance.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_W(256), .ADDR_W(32), .CNT_W(16)) a();
  dmem_arbiter_if #(.DATA_W(256), .ADDR_W(32), .CNT_W(16)) w();

  dmem_arbiter #(.TIMEOUT_CYC(1024)) dut (
    .clk_i(clk), .rst_i(rst), .bus(a.slave)
  );

  dmem_arbiter #(.TIMEOUT_CYC(8)) dut_wd (
    .clk_i(clk), .rst_i(rst), .bus(w.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    a.r0_enable_i = 0; a.r0_write_i = 0; a.r0_addr_i = '0; a.r0_data_i = '0;
    a.r1_enable_i = 0; a.r1_write_i = 0; a.r1_addr_i = '0; a.r1_data_i = '0;
    a.mem_ack_i = 0; a.mem_data_i = '0;
    w.r0_enable_i = 0; w.r0_write_i = 0; w.r0_addr_i = '0; w.r0_data_i = '0;
    w.r1_enable_i = 0; w.r1_write_i = 0; w.r1_addr_i = '0; w.r1_data_i = '0;
    w.mem_ack_i = 0; w.mem_data_i = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    a.r0_enable_i = 1; a.r1_enable_i = 1;
    rst = 1;
    tick();
    tick();
    checks++; if (a.mem_enable_o !== 1'b0) begin failures++;
      $display("FAIL reset_mem_enable got=%b exp=0", a.mem_enable_o); end
    checks++; if ({a.r0_ack_o, a.r1_ack_o} !== 2'b00) begin failures++;
      $display("FAIL reset_acks got=%b exp=00", {a.r0_ack_o, a.r1_ack_o}); end
    checks++; if (a.r0_count_o !== 16'd0 || a.r1_count_o !== 16'd0) begin failures++;
      $display("FAIL reset_counts got=%0d/%0d exp=0/0", a.r0_count_o, a.r1_count_o); end
    checks++; if (a.timeout_o !== 1'b0) begin failures++;
      $display("FAIL reset_timeout got=%b exp=0", a.timeout_o); end
    rst = 0;
    tick();
    checks++; if (a.mem_enable_o !== 1'b1 || a.grant_o !== 1'b0) begin failures++;
      $display("FAIL reset_first_grant en=%b grant=%b exp=1/0", a.mem_enable_o, a.grant_o); end
  endtask

  task automatic test_single_read();
    logic seen_early;
    do_reset();
    a.r0_enable_i = 1; a.r0_write_i = 0; a.r0_addr_i = 32'h0000_0400;
    #1;
    checks++; if (a.mem_enable_o !== 1'b0) begin failures++;
      $display("FAIL read_enable_same_cycle got=%b exp=0", a.mem_enable_o); end
    tick();
    checks++; if (a.mem_enable_o !== 1'b1) begin failures++;
      $display("FAIL read_enable_next_cycle got=%b exp=1", a.mem_enable_o); end
    checks++; if (a.mem_addr_o !== 32'h0000_0400 || a.mem_write_o !== 1'b0) begin failures++;
      $display("FAIL read_addr_write got=%h/%b exp=00000400/0", a.mem_addr_o, a.mem_write_o); end
    seen_early = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      seen_early |= a.r0_ack_o | a.r1_ack_o;
    end
    checks++; if (seen_early !== 1'b0) begin failures++;
      $display("FAIL read_early_ack got=%b exp=0", seen_early); end
    a.mem_ack_i = 1; a.mem_data_i = {8{32'hCAFE_0001}};
    #1;
    checks++; if (a.r0_ack_o !== 1'b1 || a.r1_ack_o !== 1'b0) begin failures++;
      $display("FAIL read_ack got=%b%b exp=10", a.r0_ack_o, a.r1_ack_o); end
    checks++; if (a.r0_data_o !== {8{32'hCAFE_0001}}) begin failures++;
      $display("FAIL read_data got=%h exp=%h", a.r0_data_o, {8{32'hCAFE_0001}}); end
    tick();
    a.mem_ack_i = 0; a.r0_enable_i = 0;
    #1;
    checks++; if (a.r0_ack_o !== 1'b0 || a.mem_enable_o !== 1'b0) begin failures++;
      $display("FAIL read_release ack=%b en=%b exp=0/0", a.r0_ack_o, a.mem_enable_o); end
    checks++; if (a.r0_count_o !== 16'd1) begin failures++;
      $display("FAIL read_count got=%0d exp=1", a.r0_count_o); end
  endtask

  task automatic test_both_request();
    do_reset();
    a.r0_enable_i = 1; a.r0_addr_i = 32'h0000_0100;
    a.r1_enable_i = 1; a.r1_addr_i = 32'h0000_0200;
    tick();
    checks++; if (a.grant_o !== 1'b0 || a.mem_addr_o !== 32'h0000_0100) begin failures++;
      $display("FAIL both_first grant=%b addr=%h exp=0/00000100", a.grant_o, a.mem_addr_o); end
    a.mem_ack_i = 1;
    tick();
    a.mem_ack_i = 0; a.r0_enable_i = 0;
    #1;
    checks++; if (a.mem_enable_o !== 1'b0) begin failures++;
      $display("FAIL both_gap_m1 got=%b exp=0", a.mem_enable_o); end
    tick();
    checks++; if (a.mem_enable_o !== 1'b0) begin failures++;
      $display("FAIL both_gap_m2 got=%b exp=0", a.mem_enable_o); end
    tick();
    checks++; if (a.mem_enable_o !== 1'b1 || a.grant_o !== 1'b1) begin failures++;
      $display("FAIL both_second en=%b grant=%b exp=1/1", a.mem_enable_o, a.grant_o); end
    checks++; if (a.mem_addr_o !== 32'h0000_0200) begin failures++;
      $display("FAIL both_second_addr got=%h exp=00000200", a.mem_addr_o); end
    a.mem_ack_i = 1;
    #1;
    checks++; if (a.r1_ack_o !== 1'b1 || a.r0_ack_o !== 1'b0) begin failures++;
      $display("FAIL both_r1_ack got=%b%b exp=01", a.r0_ack_o, a.r1_ack_o); end
    tick();
    a.mem_ack_i = 0; a.r1_enable_i = 0;
    #1;
    checks++; if (a.r0_count_o !== 16'd1 || a.r1_count_o !== 16'd1) begin failures++;
      $display("FAIL both_counts got=%0d/%0d exp=1/1", a.r0_count_o, a.r1_count_o); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    a.r0_enable_i = 1; a.r0_write_i = 1; a.r0_addr_i = 32'h0000_1000;
    a.r0_data_i = {8{32'h5A5A_0000}};
    tick();
    checks++; if (a.mem_write_o !== 1'b1 || a.mem_data_o !== {8{32'h5A5A_0000}}) begin failures++;
      $display("FAIL b2b_wb write=%b data=%h exp=1", a.mem_write_o, a.mem_data_o); end
    a.r1_enable_i = 1; a.r1_write_i = 0; a.r1_addr_i = 32'h0000_2000;
    a.mem_ack_i = 1;
    tick();
    a.mem_ack_i = 0; a.r0_write_i = 0;
    tick();
    tick();
    checks++; if (a.grant_o !== 1'b1 || a.mem_write_o !== 1'b0 || a.mem_addr_o !== 32'h0000_2000) begin failures++;
      $display("FAIL b2b_r1 grant=%b write=%b addr=%h exp=1/0/00002000", a.grant_o, a.mem_write_o, a.mem_addr_o); end
    a.mem_ack_i = 1;
    tick();
    a.mem_ack_i = 0; a.r1_enable_i = 0;
    tick();
    tick();
    checks++; if (a.grant_o !== 1'b0 || a.mem_write_o !== 1'b0 || a.mem_addr_o !== 32'h0000_1000) begin failures++;
      $display("FAIL b2b_refill grant=%b write=%b addr=%h exp=0/0/00001000", a.grant_o, a.mem_write_o, a.mem_addr_o); end
    a.mem_ack_i = 1;
    tick();
    a.mem_ack_i = 0; a.r0_enable_i = 0;
    #1;
    checks++; if (a.r0_count_o !== 16'd2 || a.r1_count_o !== 16'd1) begin failures++;
      $display("FAIL b2b_counts got=%0d/%0d exp=2/1", a.r0_count_o, a.r1_count_o); end
  endtask

  task automatic test_stray_ack();
    do_reset();
    a.mem_ack_i = 1;
    #1;
    checks++; if ({a.r0_ack_o, a.r1_ack_o} !== 2'b00) begin failures++;
      $display("FAIL stray_idle_ack got=%b%b exp=00", a.r0_ack_o, a.r1_ack_o); end
    tick();
    a.mem_ack_i = 0;
    #1;
    checks++; if (a.mem_enable_o !== 1'b0 || a.r0_count_o !== 16'd0 || a.r1_count_o !== 16'd0) begin failures++;
      $display("FAIL stray_idle_state en=%b counts=%0d/%0d exp=0/0/0", a.mem_enable_o, a.r0_count_o, a.r1_count_o); end
    a.r1_enable_i = 1; a.r1_addr_i = 32'h0000_3000;
    tick();
    a.mem_ack_i = 1;
    tick();
    a.r1_enable_i = 0;
    #1;
    checks++; if ({a.r0_ack_o, a.r1_ack_o} !== 2'b00 || a.mem_write_o !== 1'b0) begin failures++;
      $display("FAIL stray_release_ack got=%b%b write=%b exp=00/0", a.r0_ack_o, a.r1_ack_o, a.mem_write_o); end
    tick();
    a.mem_ack_i = 0;
    tick();
    checks++; if (a.mem_enable_o !== 1'b0 || a.r1_count_o !== 16'd1 || a.r0_count_o !== 16'd0) begin failures++;
      $display("FAIL stray_release_state en=%b counts=%0d/%0d exp=0/0/1", a.mem_enable_o, a.r0_count_o, a.r1_count_o); end
  endtask

  task automatic test_watchdog();
    do_reset();
    w.r0_enable_i = 1; w.r0_addr_i = 32'h0000_4000;
    tick();
    for (int i = 0; i < 7; i++) tick();
    checks++; if (w.timeout_o !== 1'b0) begin failures++;
      $display("FAIL wd_before got=%b exp=0", w.timeout_o); end
    tick();
    checks++; if (w.timeout_o !== 1'b1) begin failures++;
      $display("FAIL wd_set got=%b exp=1", w.timeout_o); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (w.timeout_o !== 1'b1 || w.mem_enable_o !== 1'b1) begin failures++;
      $display("FAIL wd_sticky to=%b en=%b exp=1/1", w.timeout_o, w.mem_enable_o); end
    checks++; if (a.timeout_o !== 1'b0) begin failures++;
      $display("FAIL wd_long_idle got=%b exp=0", a.timeout_o); end
    w.r0_enable_i = 0;
    rst = 1;
    tick();
    rst = 0;
    #1;
    checks++; if (w.mem_enable_o !== 1'b0 || w.timeout_o !== 1'b0 || w.r0_count_o !== 16'd0) begin failures++;
      $display("FAIL wd_reset en=%b to=%b cnt=%0d exp=0/0/0", w.mem_enable_o, w.timeout_o, w.r0_count_o); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_both_request();
    test_back_to_back();
    test_stray_ack();
    test_watchdog();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
